// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction width, default PC width, fetch FSM
// states and the fetch entry payload handed from fetch to decode.
package cpu_pkg;

  localparam int unsigned INST_W   = 16;
  localparam int unsigned PC_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0]   inst;
    logic [PC_W_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode handshake and
// execute redirect/halt controls. master = fetch unit, slave = its environment.
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
);

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              halt;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc, halt
  );

endinterface

// File: rtl/fetch_fifo.sv
// In-order instruction buffer with registered storage; head is read straight
// from the storage registers so decode never sees a path from memory data.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  fetch_entry_t                     push_data,
  input  logic                             pop,
  input  logic                             flush,
  output fetch_entry_t                     head,
  output logic [$clog2(DEPTH + 1)-1:0]     count,
  output logic                             full,
  output logic                             empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_en = pop && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_en) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop_en);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited imem issue, stale-response
// discard after redirect, and in-order hand-off to decode.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush performance counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         perf_stall_cnt,
  output logic [15:0]         perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] discard_q;

  logic             issue;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] credit_used;
  fetch_entry_t     push_data;
  fetch_entry_t     head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Redirect overrides every transition, including a simultaneous halt.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (bus.halt) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (bus.redirect_valid) state_d = RUN;
  end

  // Buffered entries plus in-flight requests (stale ones included) never exceed the FIFO depth.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign issue = (state_q == RUN) && !bus.redirect_valid
              && (credit_used < SUM_W'(FIFO_DEPTH));

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;

  // Live requests are consecutive from the last redirect, so the oldest one sits at pc - live_count.
  assign push = bus.imem_rvalid && (discard_q == '0) && !bus.redirect_valid;
  assign pop  = !fifo_empty && bus.inst_ready && !bus.redirect_valid;
  assign push_data.inst = bus.imem_rdata;
  assign push_data.pc   = PC_W_DEF'(pc_q - PC_W'(outstanding_q - discard_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= PC_W'(RESET_PC);
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_q + CNT_W'(issue) - CNT_W'(bus.imem_rvalid);
      if (bus.redirect_valid) begin
        pc_q      <= bus.redirect_pc;
        discard_q <= outstanding_q - CNT_W'(bus.imem_rvalid);
      end else begin
        if (issue) pc_q <= pc_q + PC_W'(1);
        if (bus.imem_rvalid && (discard_q != '0)) discard_q <= discard_q - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.inst_valid = !fifo_empty;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = PC_W'(head.pc);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!fifo_empty && !bus.inst_ready && (perf_stall_cnt != 16'hFFFF))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (bus.redirect_valid && (perf_flush_cnt != 16'hFFFF))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory with variable latency
// plus a queue-based reference model of fetch, credit, discard and hand-off.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(8)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  fetch_unit #(
    .PC_W       (8),
    .RESET_PC   (0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  typedef struct {
    int addr;
    int due;
    bit stale;
  } req_t;

  typedef struct {
    logic [15:0] inst;
    logic [7:0]  pc;
  } ent_t;

  req_t        inflight[$];
  ent_t        fifo_m[$];
  logic [15:0] mem [256];
  int          m_pc;
  bit          m_started;
  bit          m_halted;
  int          m_stall;
  int          m_flush;
  int          cyc;
  int          lat;
  int          last_due;
  int          vectors;
  int          miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    fifo_m.delete();
    m_pc      = 0;
    m_started = 1'b0;
    m_halted  = 1'b0;
    m_stall   = 0;
    m_flush   = 0;
    last_due  = cyc;
  endtask

  task automatic check_reset_values();
    check("rst_imem_req",   32'(bus.imem_req),   32'd0);
    check("rst_imem_addr",  32'(bus.imem_addr),  32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst",       32'(bus.inst),       32'd0);
    check("rst_inst_pc",    32'(bus.inst_pc),    32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_stall", 32'(perf_stall_cnt), 32'd0);
    check("rst_perf_flush", 32'(perf_flush_cnt), 32'd0);
`endif
  endtask

  // One clock cycle: drive at negedge, compare after settling, advance the model, wait for next negedge.
  task automatic step(input bit ready, input bit redir, input logic [7:0] rpc, input bit hlt);
    bit   rv;
    bit   exp_req;
    bit   valid;
    req_t r;
    int   due;

    rv = (inflight.size() > 0) && (inflight[0].due == cyc);
    bus.inst_ready     = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.halt           = hlt;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rv ? mem[inflight[0].addr] : 16'($urandom);
    #1;

    valid   = fifo_m.size() > 0;
    exp_req = m_started && !m_halted && !redir && ((fifo_m.size() + inflight.size()) < 2);
    check("imem_req",   32'(bus.imem_req),   32'(exp_req));
    check("imem_addr",  32'(bus.imem_addr),  32'(m_pc));
    check("inst_valid", 32'(bus.inst_valid), 32'(valid));
    if (valid) begin
      check("inst",    32'(bus.inst),    32'(fifo_m[0].inst));
      check("inst_pc", 32'(bus.inst_pc), 32'(fifo_m[0].pc));
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall_cnt", 32'(perf_stall_cnt), 32'(m_stall));
    check("perf_flush_cnt", 32'(perf_flush_cnt), 32'(m_flush));
    if (valid && !ready && m_stall < 65535) m_stall++;
    if (redir && m_flush < 65535) m_flush++;
`endif

    if (rv) r = inflight.pop_front();
    if (redir) begin
      fifo_m.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_pc      = int'(rpc);
      m_started = 1'b1;
      m_halted  = 1'b0;
    end else begin
      if (valid && ready) void'(fifo_m.pop_front());
      if (rv && !r.stale) fifo_m.push_back('{inst: mem[r.addr], pc: 8'(r.addr)});
      if (!m_started) m_started = 1'b1;
      else if (hlt) m_halted = 1'b1;
      if (exp_req) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        inflight.push_back('{addr: m_pc, due: due, stale: 1'b0});
        m_pc = (m_pc + 1) % 256;
      end
    end

    cyc++;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    lat         = 1;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    model_reset();

    rst_n              = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
    #12;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Latency 1, decode always ready: sequential fetch from 0.
    lat = 1;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

    // Decode back-pressure then release.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

    // Latency 3: redirect to 0x40 once two requests are in flight.
    lat = 3;
    for (int i = 0; i < 20 && inflight.size() != 2; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h40, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

    // PC wrap from 0xFF to 0x00.
    lat = 1;
    step(1'b1, 1'b1, 8'hFC, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

    // Halt with one outstanding, then redirect to 0x10 resumes fetch.
    lat = 2;
    for (int i = 0; i < 20 && inflight.size() != 1; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

    // Redirect and halt collide: redirect wins.
    step(1'b1, 1'b1, 8'h80, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

    // Randomized traffic: back-pressure, latency, redirects, halts.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) lat = int'($urandom_range(1, 4));
      step($urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 4,
           8'($urandom),
           $urandom_range(0, 99) < 3);
    end

    // Asynchronous reset in the middle of traffic.
    #2;
    rst_n = 1'b0;
    bus.imem_rvalid = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    cyc++;
    model_reset();
    rst_n = 1'b1;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 99) < 80, 1'b0, 8'h00, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
